// File: rtl/sorter_pkg.sv
// Shared definitions for the iterative odd-even transposition sorter.
package sorter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N          = 8;
    localparam int DEF_W          = 8;
    localparam int DEF_APPROX_LSB = 0;

    // Bit offset of element i in a flat vector of w-bit elements.
    function automatic int idx(input int i, input int w);
        return i * w;
    endfunction

endpackage

// File: rtl/compare_swap.sv
// One compare-exchange cell; keys drop the low APPROX_LSB bits, data moves full-width.
module compare_swap #(
    parameter int W          = 8,
    parameter int APPROX_LSB = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    logic [W-1:0] key_a;
    logic [W-1:0] key_b;

    assign key_a = a >> APPROX_LSB;
    assign key_b = b >> APPROX_LSB;

    // Strict compare: equal keys stay put, which keeps the sort stable.
    assign swapped = desc ? (key_a < key_b) : (key_a > key_b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/iterative_sorter.sv
// Iterative odd-even transposition sorter, one phase per clock, with early exit
// once two consecutive phases make no swaps.
module iterative_sorter
    import sorter_pkg::*;
#(
    parameter int N          = DEF_N,
    parameter int W          = DEF_W,
    parameter int APPROX_LSB = DEF_APPROX_LSB,
    parameter int PW         = $clog2(N) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  sortIn,
    input  logic            inValid,
    output logic            inReady,
    input  logic            descending,
    output logic [N*W-1:0]  sortOut,
    output logic            outValid,
    input  logic            outReady,
    output logic [PW-1:0]   phasesUsed
);

    localparam int NE  = N / 2;
    localparam int NO  = (N - 1) / 2;
    localparam int NOW = (NO > 0) ? NO : 1;

    typedef logic [N-1:0][W-1:0] vec_t;

    state_t          state, state_d;
    vec_t            data, even_v, odd_v, net_v;
    logic            desc;
    logic [PW-1:0]   phase;
    logic            prev_clean;
    logic [NE-1:0]   even_sw;
    logic [NOW-1:0]  odd_sw;
    logic            any_sw;
    logic            accept;
    logic            finish;

    for (genvar i = 0; i < NE; i++) begin : g_even
        compare_swap #(.W(W), .APPROX_LSB(APPROX_LSB)) u_cs (
            .a(data[2*i]), .b(data[2*i+1]), .desc(desc),
            .lo(even_v[2*i]), .hi(even_v[2*i+1]), .swapped(even_sw[i])
        );
    end
    if (N % 2 == 1) begin : g_even_tail
        assign even_v[N-1] = data[N-1];
    end

    for (genvar i = 0; i < NO; i++) begin : g_odd
        compare_swap #(.W(W), .APPROX_LSB(APPROX_LSB)) u_cs (
            .a(data[2*i+1]), .b(data[2*i+2]), .desc(desc),
            .lo(odd_v[2*i+1]), .hi(odd_v[2*i+2]), .swapped(odd_sw[i])
        );
    end
    assign odd_v[0] = data[0];
    if (N % 2 == 0) begin : g_odd_tail
        assign odd_v[N-1] = data[N-1];
    end
    if (NO == 0) begin : g_odd_none
        assign odd_sw = '0;
    end

    assign net_v  = phase[0] ? odd_v : even_v;
    assign any_sw = phase[0] ? |odd_sw : |even_sw;

    always_comb begin
        state_d  = state;
        accept   = 1'b0;
        finish   = 1'b0;
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state)
            IDLE: begin
                inReady = !rst;
                if (inValid) begin
                    accept  = 1'b1;
                    state_d = SORT;
                end
            end
            SORT: begin
                // Last possible phase, or this phase and the previous one were both clean.
                if (phase == PW'(N - 1) || (prev_clean && !any_sw)) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            desc       <= 1'b0;
            phase      <= '0;
            prev_clean <= 1'b0;
            sortOut    <= '0;
            phasesUsed <= '0;
        end else if (accept) begin
            data       <= vec_t'(sortIn);
            desc       <= descending;
            phase      <= '0;
            prev_clean <= 1'b0;
        end else if (state == SORT) begin
            data       <= net_v;
            prev_clean <= !any_sw;
            if (finish) begin
                sortOut    <= net_v;
                phasesUsed <= phase + PW'(1);
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

endmodule
